// File: rtl/riscv_top_pkg.sv
// Shared constants, parser state type and bit-period helper for the RISC-V board shell.
package riscv_top_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam int         DIV_SIM   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_DATA,
        ST_RESP
    } parse_state_t;

    function automatic int calc_div(input int sim, input int clk_hz, input int baud);
        return (sim != 0) ? DIV_SIM : clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART receiver and transmitter; every bit lasts DIV clocks.
module uart_8n1 #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             cnt_clr, take_bit, frame_ok;

    // NOTE: clocked state uses <= so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
    always_comb begin
        rx_next  = rx_state;
        cnt_clr  = 1'b0;
        take_bit = 1'b0;
        frame_ok = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev && !rx_s) rx_next = RX_START;
            end
            RX_START: if (rx_cnt == HALF_END) begin
                cnt_clr = 1'b1;
                rx_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_END) begin
                cnt_clr  = 1'b1;
                take_bit = 1'b1;
                if (rx_bit == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: if (rx_cnt == BIT_END) begin
                cnt_clr  = 1'b1;
                frame_ok = rx_s;
                rx_next  = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= cnt_clr ? '0 : rx_cnt + 1'b1;
            rx_valid <= frame_ok;
            if (take_bit) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (frame_ok) rx_data <= rx_shift;
        end
    end

    // Transmitter: tx_left counts the bit slots still to finish; ones shift in behind the data.
    logic [8:0]       tx_shift;
    logic [3:0]       tx_left;
    logic [CNT_W-1:0] tx_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tx_shift <= '1;
            tx_left  <= '0;
            tx_cnt   <= '0;
        end else if (tx_left == 4'd0) begin
            tx_cnt <= '0;
            if (tx_start) begin
                tx       <= 1'b0;
                tx_shift <= {1'b1, tx_data};
                tx_left  <= 4'd10;
            end
        end else if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_left  <= tx_left - 1'b1;
            tx       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx_busy = (tx_left != 4'd0);

endmodule

// File: rtl/riscv_sys_top.sv
// Board shell: UART command monitor (W/R/G) over a byte RAM, run flag on the LED.
// Optional build macro RISCV_TOP_HEARTBEAT_EN blinks the LED while run is low.
module riscv_sys_top #(
    parameter int SIM    = 0,
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 12
) (
    input  logic EXCLK,
    input  logic btnC,
    input  logic Rx,
    output logic Tx,
    output logic led
);
    import riscv_top_pkg::*;

    localparam int DIV = calc_div(SIM, CLK_HZ, BAUD);

    logic              rx_valid, tx_start, tx_busy;
    logic [7:0]        rx_data, rd_data, addr_lo;
    logic [ADDR_W-1:0] waddr, addr_cat;
    logic              is_write, run, ram_we, go_set;
    parse_state_t      state, state_next;
    logic [7:0]        ram [2**ADDR_W];

    uart_8n1 #(.DIV(DIV)) u_uart (
        .clk      (EXCLK),
        .rst_n    (btnC),
        .rx       (Rx),
        .tx       (Tx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (rd_data),
        .tx_busy  (tx_busy)
    );

    // Address bytes above ADDR_W are dropped here, which gives the modulo-2**ADDR_W wrap.
    assign addr_cat = ADDR_W'({rx_data, addr_lo});

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        tx_start   = 1'b0;
        go_set     = 1'b0;
        case (state)
            ST_IDLE: if (rx_valid) begin
                if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_next = ST_ADDR_LO;
                else if (rx_data == CMD_GO)                      go_set     = 1'b1;
            end
            ST_ADDR_LO: if (rx_valid) state_next = ST_ADDR_HI;
            ST_ADDR_HI: if (rx_valid) state_next = is_write ? ST_DATA : ST_RESP;
            ST_DATA: if (rx_valid) begin
                ram_we     = 1'b1;
                state_next = ST_IDLE;
            end
            ST_RESP: begin
                tx_start   = !tx_busy;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge EXCLK) begin
        if (!btnC) begin
            state    <= ST_IDLE;
            run      <= 1'b0;
            is_write <= 1'b0;
            addr_lo  <= '0;
            waddr    <= '0;
        end else begin
            state <= state_next;
            if (go_set) run <= 1'b1;
            if (rx_valid && state == ST_IDLE)    is_write <= (rx_data == CMD_WRITE);
            if (rx_valid && state == ST_ADDR_LO) addr_lo  <= rx_data;
            if (rx_valid && state == ST_ADDR_HI) waddr    <= addr_cat;
        end
    end

    // NOTE: the RAM has no reset so it maps onto block RAM and keeps its contents across btnC.
    always_ff @(posedge EXCLK) begin
        if (btnC && ram_we) ram[waddr] <= rx_data;
        rd_data <= ram[addr_cat];
    end

`ifdef RISCV_TOP_HEARTBEAT_EN
    localparam int HB_W = (SIM != 0) ? 3 : 24;
    logic [HB_W-1:0] hb_cnt;
    logic            hb_led;

    always_ff @(posedge EXCLK) begin
        if (!btnC) begin
            hb_cnt <= '0;
            hb_led <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
            if (&hb_cnt) hb_led <= ~hb_led;
        end
    end

    assign led = run | hb_led;
`else
    assign led = run;
`endif

endmodule

// File: tb/tb_riscv_sys_top.sv
// Randomized bench for riscv_sys_top (SIM=1): UART-level stimulus against a byte-stream command model.
module tb_riscv_sys_top;
    localparam int DIV = 4;
    localparam int MEM = 4096;

    logic clk = 1'b0;
    logic btnC;
    logic Rx;
    logic Tx;
    logic led;

    int n_cmp = 0;
    int n_err = 0;

    riscv_sys_top #(.SIM(1), .ADDR_W(12)) dut (
        .EXCLK (clk),
        .btnC  (btnC),
        .Rx    (Rx),
        .Tx    (Tx),
        .led   (led)
    );

    always #5 clk = ~clk;

    // Reference model: command bytes are collected and interpreted once complete.
    logic [7:0]  mem_model [MEM];
    logic [7:0]  pend[$];
    logic [7:0]  exp_q[$];
    logic [39:0] got_q[$];
    int          written[$];
    bit          model_run = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_addr(input logic [7:0] lo, input logic [7:0] hi);
        return (int'(hi) * 256 + int'(lo)) % MEM;
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        pend.push_back(b);
        if (pend[0] == 8'h57) begin
            if (pend.size() == 4) begin
                mem_model[model_addr(pend[1], pend[2])] = pend[3];
                pend.delete();
            end
        end else if (pend[0] == 8'h52) begin
            if (pend.size() == 3) begin
                exp_q.push_back(mem_model[model_addr(pend[1], pend[2])]);
                pend.delete();
            end
        end else begin
            if (pend[0] == 8'h47) model_run = 1'b1;
            pend.delete();
        end
    endfunction

    // Expected line samples of one frame, one sample per clock, first sample at bit 0.
    function automatic logic [39:0] frame_vec(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] v;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) v[i] = bits[i / DIV];
        return v;
    endfunction

    // Tx monitor: records 40 samples from the first low sample; a reset mid-frame discards it.
    logic [39:0] mon_v;
    bit          mon_ok;
    initial begin
        forever begin
            @(negedge clk);
            if (btnC === 1'b1 && Tx === 1'b0) begin
                mon_v    = '0;
                mon_v[0] = Tx;
                mon_ok   = 1'b1;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    mon_v[i] = Tx;
                    if (btnC !== 1'b1) mon_ok = 1'b0;
                end
                if (mon_ok) got_q.push_back(mon_v);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1, input int gap = 6);
        Rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        Rx = stop_ok;
        repeat (DIV) @(negedge clk);
        Rx = 1'b1;
        repeat (gap) @(negedge clk);
        if (stop_ok) model_rx(b);
    endtask

    task automatic send_w(input logic [15:0] a, input logic [7:0] d);
        send_byte(8'h57);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(d);
        written.push_back(int'(a) % MEM);
    endtask

    task automatic wait_frame(input string tag);
        int          n;
        logic [7:0]  e;
        n = 0;
        while (got_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frames"}, 64'(got_q.size()), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        if (got_q.size() != 0) check(tag, 64'(got_q.pop_front()), 64'(frame_vec(e)));
    endtask

    task automatic read_check(input string tag, input logic [15:0] a);
        send_byte(8'h52);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        wait_frame(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int          n;
        int          a;
        logic [7:0]  b;
        logic [15:0] ra;

        btnC = 1'b0;
        Rx   = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("rst_tx", Tx, 1);
            check("rst_led", led, 0);
        end
        btnC = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_tx", Tx, 1);
        check("idle_led", led, 0);

        send_w(16'h0010, 8'hA5);
        read_check("rd_a5", 16'h0010);

        send_w(16'h1005, 8'h3C);
        read_check("rd_wrap", 16'h0005);

        // Corrupted address-high frame is dropped; the next good bytes finish the write.
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'h99, 1'b0);
        send_byte(8'h00);
        send_byte(8'h77);
        written.push_back(32'h20);
        read_check("rd_badstop", 16'h0020);

        send_byte(8'h00);
        repeat (60) @(negedge clk);
        check("unk_no_tx", 64'(got_q.size()), 0);
        check("unk_led", led, model_run);
        read_check("rd_after_unk", 16'h0005);

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0: send_w(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)));
                1: begin
                    a  = written[$urandom_range(0, written.size() - 1)];
                    ra = 16'(a | ($urandom_range(0, 15) << 12));
                    read_check("rd_rand", ra);
                end
                default: begin
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'h57 || b == 8'h52 || b == 8'h47);
                    send_byte(b);
                end
            endcase
        end
        check("rand_no_extra", 64'(got_q.size()), 0);

        check("pre_go_led", led, 0);
        send_byte(8'h47);
        check("go_led", led, model_run);
        send_byte(8'h13);
        check("go_sticky_led", led, 1);

        // Reset while the response to a read of 0x00 is on the line.
        send_w(16'h0123, 8'h00);
        send_byte(8'h52);
        send_byte(8'h23);
        send_byte(8'h01, 1'b1, 0);
        n = 0;
        while (Tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rst_resp_started", Tx, 0);
        repeat (8) @(negedge clk);
        btnC = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", Tx, 1);
        check("rst_mid_led", led, 0);
        repeat (5) @(negedge clk);
        btnC = 1'b1;
        pend.delete();
        exp_q.delete();
        model_run = 1'b0;
        repeat (50) @(negedge clk);
        got_q.delete();
        check("post_rst_tx", Tx, 1);
        check("post_rst_led", led, 0);
        read_check("rd_kept_123", 16'h0123);
        read_check("rd_kept_005", 16'h0005);
        read_check("rd_kept_010", 16'h0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
